// File: rtl/latency_credit_ctrl.sv
// Credit-based flow controller for a fixed-latency, non-stallable pipeline.
// Upstream transfers become single-cycle issue pulses into the pipeline only
// while a buffer slot is guaranteed for the result; results land in a
// show-ahead circular buffer that is drained by a downstream valid/ready port.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// exactly when valid and ready are both 1 in that cycle; valid never waits on
// ready, and s_ready is derived only from registered state (no m_ready path).
module latency_credit_ctrl #(
  parameter int LAT   = 2,
  parameter int DSIZE = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DSIZE-1:0] s_data,
  output logic             pipe_vld_in,
  output logic [DSIZE-1:0] pipe_data_in,
  input  logic             pipe_vld_out,
  input  logic [DSIZE-1:0] pipe_data_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic [CW-1:0]    credits,
  output logic             ovf_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  // Reject configurations the controller cannot represent.
  generate
    if (DEPTH < 1 || DEPTH > 256 || LAT < 0) begin : g_bad_param
      $error("latency_credit_ctrl: illegal LAT/DEPTH parameters");
    end
  endgenerate

  logic [CW-1:0]    used;     // in-flight + buffered items
  logic [CW-1:0]    count;    // buffered items only
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [DSIZE-1:0] mem [DEPTH];
  logic             accept;
  logic             pop;
  logic             full;
  logic             push;

  // Circular pointer advance; explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign s_ready      = (used < DEPTH_C);
  assign accept       = s_valid & s_ready;
  assign pipe_vld_in  = accept;
  assign pipe_data_in = s_data;

  assign m_valid = (count != '0);
  assign m_data  = mem[rd_ptr];
  assign pop     = m_valid & m_ready;

  // A result arriving into a full buffer is only kept if a pop frees the slot.
  assign full    = (count == DEPTH_C);
  assign push    = pipe_vld_out & (~full | pop);
  assign credits = DEPTH_C - used;

  // Credit accounting: a credit is taken on issue and returned on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used <= '0;
    end else if (accept && !pop) begin
      used <= used + CW'(1);
    end else if (pop && !accept && used != '0) begin
      used <= used - CW'(1);
    end
  end

  // Output buffer storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= pipe_data_out;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Sticky flag for a result that found no room (broken pipeline contract).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
    end else if (pipe_vld_out && full && !pop) begin
      ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_latency_credit_ctrl.sv
// Testbench for latency_credit_ctrl: a LAT-deep delay line stands in for the
// pipeline; a queue-based reference model predicts every output each cycle.
module tb_latency_credit_ctrl;

  localparam int LAT   = 2;
  localparam int DSIZE = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic             s_valid;
  logic             s_ready;
  logic [DSIZE-1:0] s_data;
  logic             pipe_vld_in;
  logic [DSIZE-1:0] pipe_data_in;
  logic             pipe_vld_out;
  logic [DSIZE-1:0] pipe_data_out;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
  logic [CW-1:0]    credits;
  logic             ovf_err;
  logic             inj_v;
  logic [DSIZE-1:0] inj_d;

  latency_credit_ctrl #(.LAT(LAT), .DSIZE(DSIZE), .DEPTH(DEPTH)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .pipe_vld_in  (pipe_vld_in),
    .pipe_data_in (pipe_data_in),
    .pipe_vld_out (pipe_vld_out),
    .pipe_data_out(pipe_data_out),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .credits      (credits),
    .ovf_err      (ovf_err)
  );

  // Fixed-latency pipeline model sharing rst_n; inj_v forces a spurious result.
  logic [LAT-1:0]   sr_v;
  logic [DSIZE-1:0] sr_d [LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_v <= '0;
      for (int i = 0; i < LAT; i++) sr_d[i] <= '0;
    end else begin
      sr_v[0] <= pipe_vld_in;
      sr_d[0] <= pipe_data_in;
      for (int i = 1; i < LAT; i++) begin
        sr_v[i] <= sr_v[i-1];
        sr_d[i] <= sr_d[i-1];
      end
    end
  end
  assign pipe_vld_out  = sr_v[LAT-1] | inj_v;
  assign pipe_data_out = inj_v ? inj_d : sr_d[LAT-1];

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit ovf_exp  = 1'b0;
  logic [DSIZE-1:0] exp_q[$];   // accepted items, oldest first
  int               vis_q[$];   // cycle in which each item becomes visible

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int buffered_now();
    int n = 0;
    foreach (vis_q[i]) if (vis_q[i] <= cyc) n++;
    return n;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, check all outputs against the model, then
  // advance the model by the transfers that happen at the coming edge.
  task automatic step(input logic sv, input logic [DSIZE-1:0] sd, input logic mr,
                      input logic inj, output bit acc);
    int  used;
    bit  exp_rdy;
    bit  exp_mv;
    bit  do_pop;
    @(negedge clk);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    inj_v   = inj;
    inj_d   = 8'hEE;
    #1;
    used    = exp_q.size();
    exp_rdy = (used < DEPTH);
    exp_mv  = (used > 0) && (vis_q[0] <= cyc);
    check("s_ready", 32'(s_ready), 32'(exp_rdy));
    check("credits", 32'(credits), 32'(DEPTH - used));
    check("pipe_vld_in", 32'(pipe_vld_in), 32'(sv && exp_rdy));
    if (sv && exp_rdy) check("pipe_data_in", 32'(pipe_data_in), 32'(sd));
    check("m_valid", 32'(m_valid), 32'(exp_mv));
    if (exp_mv) check("m_data", 32'(m_data), 32'(exp_q[0]));
    check("ovf_err", 32'(ovf_err), 32'(ovf_exp));
    do_pop = exp_mv && mr;
    if (inj && buffered_now() == DEPTH && !do_pop) ovf_exp = 1'b1;
    if (do_pop) begin
      void'(exp_q.pop_front());
      void'(vis_q.pop_front());
    end
    acc = sv && exp_rdy;
    if (acc) begin
      exp_q.push_back(sd);
      vis_q.push_back(cyc + LAT + 1);
    end
    cyc++;
  endtask

  // Hold reset for n cycles, checking reset values, then release.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n   = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      inj_v   = 1'b0;
      #1;
      exp_q.delete();
      vis_q.delete();
      ovf_exp = 1'b0;
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_credits", 32'(credits), 32'(DEPTH));
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_ovf_err", 32'(ovf_err), 32'd0);
      check("rst_pipe_vld_in", 32'(pipe_vld_in), 32'd0);
      cyc++;
    end
    #1 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    int idx;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    inj_v   = 1'b0;
    inj_d   = '0;

    // Reset state.
    do_reset(2);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);

    // Single transfer, held in the buffer for a while, then drained.
    step(1'b1, 8'h5A, 1'b0, 1'b0, acc);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Streaming with m_ready held high.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0, acc);
    for (int i = 0; i < LAT + 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Back-pressure: fill with m_ready low, then release; hold data until taken.
    idx = 1;
    for (int c = 0; c < 40 && idx <= 6; c++) begin
      step(1'b1, 8'(idx), (c >= 10), 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_all_accepted", 32'(idx), 32'd7);
    for (int i = 0; i < LAT + 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Full buffer, then s_valid and m_ready both high: pointers wrap repeatedly.
    for (int i = 0; i < DEPTH + LAT + 2; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, acc);
    for (int i = 0; i < 24; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, acc);
    for (int i = 0; i < LAT + 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Randomized traffic: light and heavy back-pressure.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0, 1'b0, acc);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) == 0, 1'b0, acc);

    // Reset with items buffered and in flight; nothing stale may emerge.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, acc);
    do_reset(2);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Spurious result into a full buffer: dropped, sticky error flag.
    for (int i = 0; i < DEPTH + LAT + 2; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, acc);
    for (int i = 0; i < LAT + 2; i++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check("ovf_sticky_end", 32'(ovf_err), 32'd1);

    // Final report.
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
